// File: rtl/fre_count.sv
// fre_count: measurement end of the frequency-meter gate interface.
// Counts rising edges of sig_in during the count_en gate window as a
// DIGITS-digit BCD number. On a load rising edge in HOLD, the count is
// latched for the display path. A count_clr level clears the counter
// before the next window starts.
//
// Ports:
//   clk       fast sampling clock (>= 4x max sig_in frequency)
//   rst       asynchronous active-high reset
//   sig_in    unknown signal being measured (asynchronous)
//   count_en  gate window from the controller (asynchronous)
//   count_clr clear request, level-sensitive (asynchronous)
//   load      result-latch request, rising-edge triggered (asynchronous)
//   bcd_out   latched BCD result, digit 0 in [3:0]
//   overflow  latched flag: the count wrapped past all-9s in the window
//   valid     high once any result has been latched since reset
module fre_count #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig_in,
    input  logic                count_en,
    input  logic                count_clr,
    input  logic                load,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                overflow,
    output logic                valid
);

    typedef enum logic [1:0] {IDLE, GATE, HOLD} state_t;

    // Bit order in each synchroniser lane: {load, count_clr, count_en, sig_in}.
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  synced;
    logic [3:0]                  synced_d;
    logic                        sig_s, en_s, clr_s, load_s;
    logic                        sig_rise, en_rise, en_fall, load_rise;

    state_t                      state_q, state_d;
    logic [4*DIGITS-1:0]         cnt_q, cnt_inc;
    logic                        ovf_run_q;
    logic                        wrap;
    logic                        carry;
    logic                        latch_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            synced_d <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], {load, count_clr, count_en, sig_in}};
            synced_d <= synced;
        end
    end

    assign synced    = sync_q[SYNC_STAGES-1];
    assign sig_s     = synced[0];
    assign en_s      = synced[1];
    assign clr_s     = synced[2];
    assign load_s    = synced[3];
    assign sig_rise  = sig_s & ~synced_d[0];
    assign en_rise   = en_s & ~synced_d[1];
    assign en_fall   = ~en_s & synced_d[1];
    assign load_rise = load_s & ~synced_d[3];

    // Ripple BCD increment. Each digit at 9 rolls to 0 and passes the carry.
    // A carry out of the top digit marks a wrap of the whole counter.
    always_comb begin
        cnt_inc = cnt_q;
        carry   = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = '0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_rise) state_d = GATE;
            GATE:    if (en_fall) state_d = HOLD;
            HOLD:    if (clr_s)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign latch_en = (state_q == HOLD) && load_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ovf_run_q <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            state_q <= state_d;
            // A clear takes priority over an increment in the same cycle.
            if (clr_s) begin
                cnt_q     <= '0;
                ovf_run_q <= 1'b0;
            end else if (state_q == GATE && sig_rise) begin
                cnt_q <= cnt_inc;
                if (wrap) ovf_run_q <= 1'b1;
            end
            // The latch sees the pre-clear count, even when a clear arrives
            // in the same cycle.
            if (latch_en) begin
                bcd_out  <= cnt_q;
                overflow <= ovf_run_q;
                valid    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fre_count.md
Name: fre_count

Overview:
Measurement end of the frequency-meter gate interface. It consumes the gate-controller outputs count_en, count_clr and load, and counts rising edges of the unknown input sig_in during the gate window as a DIGITS-digit BCD number. It latches the result for the display path on the load edge, then clears for the next window. All inputs except clk are asynchronous to clk and are synchronised internally.

Parameters:
DIGITS, 4, number of BCD digits in the counter and the latched result
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2)

Ports:
clk  input  1  fast sampling clock; must be at least 4x the maximum sig_in frequency
rst  input  1  asynchronous, active-high reset
sig_in  input  1  unknown signal being measured, asynchronous
count_en  input  1  gate window from the controller; high means counting is allowed
count_clr  input  1  clear request from the controller, level-sensitive
load  input  1  result-latch request from the controller; acts on its rising edge
bcd_out  output  4*DIGITS  latched result; digit 0 in [3:0], most significant digit at the top
overflow  output  1  latched flag: the count wrapped past all-9s during the window
valid  output  1  high once at least one result has been latched since reset

Behaviour:
- Interface fixed: one clock clk; rst is asynchronous and active-high.
- Reset: all synchroniser flops, edge registers, counter and ovf_run go to 0; state goes to IDLE; bcd_out=0, overflow=0, valid=0.
- Synchronisers: sig_in, count_en, count_clr and load each pass through SYNC_STAGES flops, giving sig_s, en_s, clr_s, load_s.
  - One extra register per signal gives edge detects: sig_rise, en_rise, en_fall, load_rise.
  - Input-to-effect latency is SYNC_STAGES+1 clk cycles.
- FSM, three states:
  - IDLE: en_rise goes to GATE.
  - GATE: each sig_rise increments the counter. en_fall goes to HOLD.
  - HOLD: on load_rise, latch the result and stay in HOLD. On clr_s, go to IDLE.
- Clear: clr_s high in any state zeroes the counter and ovf_run.
  - In GATE the state is unchanged.
  - Clear has priority over increment in the same cycle.
- BCD increment: digit 0 adds 1. A digit at 9 goes to 0 and carries into the next digit. Digits never hold values above 9.
  - All digits at 9 wraps to all zeros and sets ovf_run (sticky until clear).
- Latch, on load_rise in HOLD only:
  - bcd_out <= counter value at the start of that cycle.
  - overflow <= ovf_run.
  - valid <= 1.
  - load_rise in IDLE or GATE is ignored; this covers the load high that the controller drives at reset.
- Simultaneous load_rise and clr_s in HOLD: the latch captures the pre-clear value, then the counter clears and the state goes to IDLE.
- clr_s in HOLD before any load_rise: the window is discarded. bcd_out, overflow and valid are unchanged.
- en_rise while in HOLD is ignored; a new window always starts from IDLE.
- sig_in high and low times must each be at least 2 clk periods. Faster input is out of spec and may under-count.
- rst asserted mid-window aborts immediately. All outputs return to reset values; no partial result is latched.

Test Plan:
- Reset, then run one controller cycle with 1234 sig_in pulses inside the gate: bcd_out=16'h1234, overflow=0, valid=1 after load.
- DIGITS=4 with 10005 pulses in the gate: bcd_out=16'h0005, overflow=1; the next window with 7 pulses gives 16'h0007, overflow=0.
- 50 pulses before count_en rises and 30 after it falls, 100 inside: bcd_out=16'h0100.
- Load held high during reset, then released: valid stays 0 and bcd_out stays 0 until the first real HOLD latch.
- Assert rst halfway through a 500-pulse gate, then run a clean window of 42 pulses: outputs are 0/0/0 during reset, then bcd_out=16'h0042.
- Clear without load in HOLD after a 99-pulse window: the previous bcd_out is retained and valid is unchanged. The next window of 3 pulses gives 16'h0003 (the counter restarted from 0).
